// File: rtl/oa21_arb_pkg.sv
// Shared types and constants for the OR-AND qualified round-robin arbiter.
package oa21_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RECOVER = 2'd2
    } arb_state_e;

    // Width of the grant hold counter; bounds HOLD_MAX to 255.
    localparam int HOLD_CNT_W = 8;

    // Bits needed to index n lanes (at least one bit).
    function automatic int lane_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/oa21_rr_pick.sv
// Circular first-one finder: returns the first set bit of mask at or after
// ptr, wrapping from N-1 back to 0, plus a flag saying whether any bit is set.
module oa21_rr_pick
    import oa21_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = lane_w(N)
) (
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          found
);

    logic [N-1:0] rot;
    logic [IW:0]  sum;

    // Rotate so that bit 0 of rot corresponds to lane ptr.
    assign rot = N'({mask, mask} >> ptr);

    // Scan from the far end so the lowest rotated offset wins, then map back to a lane.
    always_comb begin
        found = 1'b0;
        sum   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                sum   = {1'b0, ptr} + (IW + 1)'(k);
            end
        end
        if (sum >= (IW + 1)'(N)) begin
            sum = sum - (IW + 1)'(N);
        end
        idx = sum[IW-1:0];
    end

endmodule

// File: rtl/oa21_rr_arbiter.sv
// Round-robin arbiter with OR-AND qualified requests, registered one-hot
// grants, hold timeout and a single RECOVER turnaround cycle per grant.
module oa21_rr_arbiter
    import oa21_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int HOLD_MAX = 8
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic [N-1:0]         REQ,
    input  logic [N-1:0]         PRI,
    input  logic [N-1:0]         EN,
    input  logic                 DONE,
    output logic [N-1:0]         GNT,
    output logic                 GNT_VLD,
    output logic [$clog2(N)-1:0] GNT_ID,
    output logic                 ABORT,
    output logic                 BUSY
);

    localparam int IW = lane_w(N);
    localparam logic [N-1:0] LANE0 = N'(1);
    localparam logic [HOLD_CNT_W-1:0] HOLD_LIM = HOLD_CNT_W'(HOLD_MAX);

    arb_state_e            state;
    logic [IW-1:0]         ptr;
    logic [IW-1:0]         owner;
    logic [HOLD_CNT_W-1:0] cnt;

    logic [N-1:0]  eff;
    logic [N-1:0]  hi;
    logic [IW-1:0] hi_idx;
    logic [IW-1:0] eff_idx;
    logic          hi_found;
    logic          eff_found;
    logic [IW-1:0] sel;
    logic          owner_en;
    logic          release_now;
    logic [IW-1:0] ptr_next;

    // A lane requests when REQ or PRI is high and its enable is set.
    assign eff = (REQ | PRI) & EN;
    assign hi  = PRI & EN;

    oa21_rr_pick #(.N(N), .IW(IW)) u_pick_hi (
        .mask  (hi),
        .ptr   (ptr),
        .idx   (hi_idx),
        .found (hi_found)
    );

    oa21_rr_pick #(.N(N), .IW(IW)) u_pick_eff (
        .mask  (eff),
        .ptr   (ptr),
        .idx   (eff_idx),
        .found (eff_found)
    );

    // Any priority request preempts the normal round-robin choice.
    assign sel = hi_found ? hi_idx : eff_idx;

    assign owner_en    = EN[owner];
    assign release_now = !owner_en || DONE || (cnt == HOLD_LIM);
    assign ptr_next    = (owner == IW'(N - 1)) ? '0 : owner + IW'(1);

    // Arbitration FSM; every output is registered alongside the state.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state   <= IDLE;
            ptr     <= '0;
            owner   <= '0;
            cnt     <= '0;
            GNT     <= '0;
            GNT_VLD <= 1'b0;
            GNT_ID  <= '0;
            ABORT   <= 1'b0;
            BUSY    <= 1'b0;
        end else begin
            ABORT <= 1'b0;
            case (state)
                IDLE: begin
                    if (eff_found) begin
                        state   <= GRANT;
                        owner   <= sel;
                        cnt     <= HOLD_CNT_W'(1);
                        GNT     <= LANE0 << sel;
                        GNT_VLD <= 1'b1;
                        GNT_ID  <= sel;
                        BUSY    <= 1'b1;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        // EN drop outranks DONE; a release without DONE is an EN drop or timeout.
                        state   <= RECOVER;
                        GNT     <= '0;
                        GNT_VLD <= 1'b0;
                        GNT_ID  <= '0;
                        ABORT   <= !owner_en || !DONE;
                    end else begin
                        cnt <= cnt + HOLD_CNT_W'(1);
                    end
                end
                RECOVER: begin
                    state <= IDLE;
                    ptr   <= ptr_next;
                    BUSY  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oa21_rr_arbiter.sv
// Self-checking bench for oa21_rr_arbiter: directed scenarios plus random
// traffic compared cycle by cycle against a behavioural ownership model.
module tb_oa21_rr_arbiter;

    localparam int N        = 4;
    localparam int HOLD_MAX = 8;

    logic         CLK = 1'b0;
    logic         RSTN;
    logic [N-1:0] REQ;
    logic [N-1:0] PRI;
    logic [N-1:0] EN;
    logic         DONE;
    logic [N-1:0] GNT;
    logic         GNT_VLD;
    logic [1:0]   GNT_ID;
    logic         ABORT;
    logic         BUSY;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: owner lane (-1 = nobody), cycles held, rotation start, turnaround flag.
    int m_owner;
    int m_held;
    int m_ptr;
    int m_last;
    bit m_turn;
    bit m_abort;

    int hi_cnt;

    oa21_rr_arbiter #(.N(N), .HOLD_MAX(HOLD_MAX)) dut (
        .CLK     (CLK),
        .RSTN    (RSTN),
        .REQ     (REQ),
        .PRI     (PRI),
        .EN      (EN),
        .DONE    (DONE),
        .GNT     (GNT),
        .GNT_VLD (GNT_VLD),
        .GNT_ID  (GNT_ID),
        .ABORT   (ABORT),
        .BUSY    (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int first_from(input logic [N-1:0] m, input int p);
        logic [N-1:0] sh;
        for (int k = 0; k < N; k++) begin
            sh = m >> ((p + k) % N);
            if (sh[0]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_ptr   = 0;
        m_last  = 0;
        m_turn  = 1'b0;
        m_abort = 1'b0;
    endtask

    task automatic model_release(input bit is_abort);
        m_abort = is_abort;
        m_last  = m_owner;
        m_owner = -1;
        m_turn  = 1'b1;
    endtask

    // One clock edge of the arbitration rules, using the inputs the DUT sees.
    task automatic model_step();
        logic [N-1:0] eff;
        logic [N-1:0] hi;
        logic [N-1:0] en_sh;
        int           s;
        eff     = (REQ | PRI) & EN;
        hi      = PRI & EN;
        m_abort = 1'b0;
        if (m_owner >= 0) begin
            en_sh = EN >> m_owner;
            if (!en_sh[0])                model_release(1'b1);
            else if (DONE)                model_release(1'b0);
            else if (m_held == HOLD_MAX)  model_release(1'b1);
            else                          m_held++;
        end else if (m_turn) begin
            m_turn = 1'b0;
            m_ptr  = (m_last + 1) % N;
        end else begin
            s = (hi != '0) ? first_from(hi, m_ptr) : first_from(eff, m_ptr);
            if (s >= 0) begin
                m_owner = s;
                m_held  = 1;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        int exp_gnt;
        exp_gnt = (m_owner >= 0) ? (1 << m_owner) : 0;
        check({tag, "_gnt"},  32'(GNT),     32'(exp_gnt));
        check({tag, "_vld"},  32'(GNT_VLD), 32'(m_owner >= 0));
        check({tag, "_id"},   32'(GNT_ID),  32'((m_owner >= 0) ? m_owner : 0));
        check({tag, "_abrt"}, 32'(ABORT),   32'(m_abort));
        check({tag, "_busy"}, 32'(BUSY),    32'((m_owner >= 0) || m_turn));
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_step();
        #1;
        check_outputs("cyc");
    endtask

    // Assert reset between edges; outputs must clear without waiting for a clock.
    task automatic async_reset();
        #2 RSTN = 1'b0;
        #1;
        check("rst_gnt",  32'(GNT),     32'h0);
        check("rst_vld",  32'(GNT_VLD), 32'h0);
        check("rst_id",   32'(GNT_ID),  32'h0);
        check("rst_abrt", 32'(ABORT),   32'h0);
        check("rst_busy", 32'(BUSY),    32'h0);
        model_reset();
        #1 RSTN = 1'b1;
    endtask

    initial begin
        RSTN = 1'b1;
        REQ  = '0;
        PRI  = '0;
        EN   = '0;
        DONE = 1'b0;
        model_reset();
        #2 RSTN = 1'b0;
        #1;
        check("init_gnt",  32'(GNT),   32'h0);
        check("init_busy", 32'(BUSY),  32'h0);
        check("init_abrt", 32'(ABORT), 32'h0);
        repeat (2) @(posedge CLK);
        @(negedge CLK) RSTN = 1'b1;
        cycle();

        // Basic rotation: lane 0 first, then lane 2 because the pointer moved past 0.
        REQ = 4'b0101; EN = 4'b1111;
        cycle();
        check("t1_first", 32'(GNT), 32'h1);
        DONE = 1'b1; cycle();
        DONE = 1'b0; cycle();
        cycle();
        check("t1_second", 32'(GNT), 32'h4);
        DONE = 1'b1; cycle();
        DONE = 1'b0; REQ = '0; cycle();
        cycle();

        // Priority override from a freshly reset pointer.
        async_reset();
        REQ = 4'b0011; PRI = 4'b1000; EN = 4'b1111;
        cycle();
        check("t2_pri_id", 32'(GNT_ID), 32'd3);
        DONE = 1'b1; PRI = '0; cycle();
        DONE = 1'b0; cycle();
        cycle();
        check("t2_lane0", 32'(GNT_ID), 32'd0);
        DONE = 1'b1; cycle();
        DONE = 1'b0; cycle();
        cycle();
        check("t2_lane1", 32'(GNT_ID), 32'd1);
        DONE = 1'b1; cycle();
        DONE = 1'b0; REQ = '0; cycle();
        cycle();

        // Enable gating and abort on enable drop.
        REQ = 4'b0010; EN = 4'b1101;
        cycle();
        cycle();
        check("t3_gated", 32'(GNT), 32'h0);
        EN = 4'b1111; cycle();
        check("t3_grant", 32'(GNT), 32'h2);
        EN = 4'b1101; cycle();
        check("t3_abort", 32'(ABORT), 32'h1);
        check("t3_gnt0",  32'(GNT),   32'h0);
        REQ = '0; EN = 4'b1111; cycle();
        cycle();

        // Hold timeout: lane 2 never signals DONE.
        REQ = 4'b0100;
        cycle();
        hi_cnt = 0;
        for (int i = 0; i < 20 && GNT[2]; i++) begin
            hi_cnt++;
            cycle();
        end
        check("t4_len",   32'(hi_cnt), 32'(HOLD_MAX));
        check("t4_abort", 32'(ABORT),  32'h1);
        REQ = 4'b1111; cycle();
        cycle();
        check("t4_ptr3", 32'(GNT_ID), 32'd3);

        // DONE and EN drop together on lane 3: abort wins, pointer wraps to 0.
        DONE = 1'b1; EN = 4'b0111; cycle();
        check("t5_abort", 32'(ABORT), 32'h1);
        DONE = 1'b0; EN = 4'b1111; cycle();
        cycle();
        check("t5_wrap", 32'(GNT_ID), 32'd0);

        // Async reset in the middle of a grant.
        repeat (4) cycle();
        async_reset();
        REQ = 4'b0110;
        cycle();
        check("t6_gnt", 32'(GNT), 32'h2);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            REQ  = N'($urandom) & N'($urandom);
            PRI  = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
            EN   = N'($urandom) | N'($urandom);
            DONE = ($urandom_range(0, 3) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/oa21_rr_arbiter.md
# oa21_rr_arbiter

Round-robin arbiter that shares one downstream resource among N requesters, each qualified by an OR-AND term: a lane's effective request is (REQ | PRI) & EN. Grants are registered, one-hot, and held until the owner signals DONE, its enable drops, or a hold timeout expires. A single turnaround cycle follows every grant. Sits between the requester lanes and the shared datapath, which it sequences by ownership.

## Interface
- N, default 4, number of requester lanes (2..16)
- HOLD_MAX, default 8, maximum grant cycles before forced release (1..255)
- CLK  in  1  rising-edge clock
- RSTN  in  1  asynchronous active-low reset
- REQ  in  N  normal request per lane
- PRI  in  N  priority request per lane; also counts as a request
- EN  in  N  lane qualifier; lane ignored while 0
- DONE  in  1  owner releases resource this cycle
- GNT  out  N  one-hot grant, 0 when no owner
- GNT_VLD  out  1  OR of GNT
- GNT_ID  out  $clog2(N)  index of owner, 0 when GNT_VLD=0
- ABORT  out  1  one-cycle pulse: grant ended by timeout or owner EN drop
- BUSY  out  1  1 in GRANT or RECOVER

## Operation
- eff[i] = (REQ[i] | PRI[i]) & EN[i]; hi[i] = PRI[i] & EN[i].
- Selection: if any hi, pick first hi at or after pointer PTR (circular); else first eff at or after PTR.
- States: IDLE, GRANT, RECOVER.
- IDLE: if any eff, load owner = selected, cnt = 1, go GRANT; else stay.
- GRANT: GNT = onehot(owner). Priority of exit causes (same cycle): EN[owner]=0 -> ABORT, RECOVER; else DONE=1 -> RECOVER (no ABORT); else cnt==HOLD_MAX -> ABORT, RECOVER; else cnt++.
- REQ/PRI of owner dropping while GRANT does not release; only DONE, EN, timeout do.
- DONE ignored outside GRANT.
- RECOVER: GNT=0, PTR = owner+1 mod N, go IDLE; no new grant this cycle.
- PTR updates only on RECOVER entry-exit; PTR wraps N-1 -> 0.
- cnt is 8 bits, saturates never (bounded by HOLD_MAX).
- Reset (async, any state): state IDLE, PTR 0, owner 0, cnt 0, GNT 0, GNT_VLD 0, GNT_ID 0, ABORT 0, BUSY 0.

## Timing
- All outputs registered; no combinational path input->output.
- Request sampled at edge k in IDLE -> GNT asserted after edge k (visible cycle k+1); latency 1.
- DONE sampled high at edge m -> GNT low after edge m; ABORT/RECOVER same edge.
- Minimum grant length 1 cycle (DONE high on first grant cycle); max HOLD_MAX cycles.
- Back-to-back grants separated by exactly one GNT=0 cycle (RECOVER) and one IDLE selection cycle: next GNT earliest 2 cycles after release edge.
- ABORT high exactly one cycle, coincident with first RECOVER cycle.
- RSTN asserted mid-grant: GNT drops asynchronously; no ABORT pulse.

## Structure
- Shared package oa21_arb_pkg: state enum (IDLE, GRANT, RECOVER), HOLD counter width constant (8), lane index width function.
- One sub-module: oa21_rr_pick (combinational circular first-one finder given mask and pointer, returns index and found flag); instantiated twice (hi, eff).
- Effective-request OR-AND per lane built inline.

## Test plan
- Reset, N=4: REQ=4'b0101, EN=4'b1111 -> GNT=4'b0001 one cycle later; DONE pulse -> RECOVER, then GNT=4'b0100 (PTR=1 skips lane 1).
- PRI override: REQ=4'b0011, PRI=4'b1000, EN=1111, PTR=0 -> GNT_ID=3 first; afterwards lane 0 then 1.
- EN gating: REQ=4'b0010, EN=4'b1101 -> GNT stays 0; raise EN[1] -> GNT=4'b0010 next cycle; drop EN[1] mid-grant -> ABORT=1, GNT=0.
- Timeout, HOLD_MAX=8: hold REQ[2], never DONE -> GNT high exactly 8 cycles, ABORT on 9th, PTR=3.
- Wrap and simultaneous: owner lane 3 with DONE and EN[3]=0 same cycle -> ABORT=1 (EN wins); PTR wraps to 0.
- Async reset during GRANT (cnt=5) -> GNT, BUSY, ABORT all 0 immediately; first grant after release uses PTR=0.
